// File: rtl/alu_srcb_pkg.sv
// Shared codes and types for the ALU operand-B stage.
// Optional lui-style extension is enabled with ALU_SRCB_UPPER_EN.
package alu_srcb_pkg;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_STEP   = 2'b01;
    localparam logic [1:0] SRCB_EXT    = 2'b10;
    localparam logic [1:0] SRCB_EXT_SH = 2'b11;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    // Occupancy of the main + skid register pair.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b10
    } occ_e;

endpackage

// File: rtl/srcb_extend.sv
// Combinational immediate extension and operand-B source selection.
// ALU_SRCB_UPPER_EN adds the lui form for ext_mode=10; otherwise it sign-extends.
module srcb_extend
    import alu_srcb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned STEP   = 4,
    parameter int unsigned SHAMT  = 2
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        ext_mode,
    input  logic [1:0]        alu_src_b,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] operand
);

    logic [DATA_W-1:0] ext_sign;
    logic [DATA_W-1:0] ext_zero;
    logic [DATA_W-1:0] ext;

    assign ext_sign = DATA_W'($signed(imm));
    assign ext_zero = DATA_W'(imm);

`ifdef ALU_SRCB_UPPER_EN
    logic [DATA_W-1:0] ext_upper;
    assign ext_upper = DATA_W'(imm) << (DATA_W - IMM_W);
`endif

    always_comb begin
        ext = ext_sign;
        case (ext_mode)
            EXT_ZERO: ext = ext_zero;
            EXT_UPPER: begin
`ifdef ALU_SRCB_UPPER_EN
                ext = ext_upper;
`else
                ext = ext_sign;
`endif
            end
            default: ext = ext_sign;
        endcase
    end

    always_comb begin
        operand = rt_data;
        case (alu_src_b)
            SRCB_RT:     operand = rt_data;
            SRCB_STEP:   operand = DATA_W'(STEP);
            SRCB_EXT:    operand = ext;
            SRCB_EXT_SH: operand = ext << SHAMT;
            default:     operand = rt_data;
        endcase
    end

endmodule

// File: rtl/alu_srcb_stage.sv
// Registered operand-B selector with a valid/ready output and 2-entry skid buffer.
// in_ready is a flop, so it never depends combinationally on out_ready.
module alu_srcb_stage
    import alu_srcb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned STEP   = 4,
    parameter int unsigned SHAMT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        alu_src_b,
    input  logic [1:0]        ext_mode,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic              out_valid,
    input  logic              out_ready
);

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]        main_src_q, main_src_d;
    logic [1:0]        skid_src_q, skid_src_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] sel_data;
    logic              in_xfer;
    logic              out_xfer;

    srcb_extend #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .STEP   (STEP),
        .SHAMT  (SHAMT)
    ) u_extend (
        .imm       (imm),
        .ext_mode  (ext_mode),
        .alu_src_b (alu_src_b),
        .rt_data   (rt_data),
        .operand   (sel_data)
    );

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_data_q;
    assign out_src   = main_src_q;
    assign in_ready  = in_ready_q;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_src_d  = main_src_q;
        skid_data_d = skid_data_q;
        skid_src_d  = skid_src_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    main_data_d = sel_data;
                    main_src_d  = alu_src_b;
                    state_d     = StOne;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = sel_data;
                    main_src_d  = alu_src_b;
                end else if (in_xfer) begin
                    skid_data_d = sel_data;
                    skid_src_d  = alu_src_b;
                    state_d     = StFull;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_src_d  = skid_src_q;
                    skid_data_d = '0;
                    skid_src_d  = '0;
                    state_d     = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_src_q  <= '0;
            skid_data_q <= '0;
            skid_src_q  <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_src_q  <= main_src_d;
            skid_data_q <= skid_data_d;
            skid_src_q  <= skid_src_d;
            in_ready_q  <= in_ready_d;
        end
    end

endmodule
